// File: rtl/fft_mem_sequencer.sv
// fft_mem_sequencer: drives a 64-entry dual-port RAM through bit-reversed load,
// six in-place radix-2 DIT butterfly stages, and natural-order unload.
module fft_mem_sequencer #(
  parameter int WIDTH  = 32,
  parameter int BF_LAT = 2
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Start,
  output logic               Busy,
  output logic               Done,
  input  logic               In_Valid,
  output logic               In_Ready,
  input  logic [2*WIDTH-1:0] In_Data,
  output logic               Ram_En,
  output logic               Ram_We_A,
  output logic [5:0]         Ram_Addr_A,
  output logic [2*WIDTH-1:0] Ram_DI_A,
  output logic               Ram_We_B,
  output logic [5:0]         Ram_Addr_B,
  output logic [2*WIDTH-1:0] Ram_DI_B,
  input  logic [2*WIDTH-1:0] Ram_DO_A,
  input  logic [2*WIDTH-1:0] Ram_DO_B,
  output logic               Bf_Valid,
  output logic [4:0]         Tw_Addr,
  input  logic [2*WIDTH-1:0] Bf_Res_A,
  input  logic [2*WIDTH-1:0] Bf_Res_B,
  output logic               Out_Valid,
  output logic [5:0]         Out_Index
);
  localparam int CW = $clog2(64 + BF_LAT + 1);
  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, UNLOAD, DONE} state_t;
  if (BF_LAT < 0 || BF_LAT % 2 != 0) begin : g_bad_lat
    $error("BF_LAT must be even and non-negative");
  end
  state_t          state_q, state_d;
  logic [5:0]      k_q;
  logic [CW-1:0]   c_q;
  logic [2:0]      s_q;
  logic [6:0]      j_q;
  logic [BF_LAT:0] v_q;
  logic [5:0]      top_q [BF_LAT+1];
  logic [5:0]      bot_q [BF_LAT+1];
  logic [4:0]      tw_q;
  logic            ov_q;
  logic [5:0]      oi_q;
  logic            xfer, rd, wr, urd, stage_end;
  logic [5:0]      bx, span, top, bot;
  logic [4:0]      tw;
  logic            unused_do;
  assign unused_do = ^{Ram_DO_A, Ram_DO_B};
  // c_q is the stage-relative cycle: reads on even c<64, writes drain BF_LAT+1 later
  always_comb begin
    xfer      = state_q == LOAD && In_Valid;
    stage_end = state_q == COMPUTE && c_q == CW'(63 + BF_LAT);
    rd        = state_q == COMPUTE && !c_q[0] && c_q < CW'(64);
    wr        = state_q == COMPUTE && v_q[BF_LAT];
    urd       = state_q == UNLOAD && !j_q[6];
    bx        = {1'b0, c_q[5:1]};
    span      = 6'd1 << s_q;
    top       = ((bx >> s_q) << (s_q + 3'd1)) | (bx & (span - 6'd1));
    bot       = top + span;
    tw        = 5'((bx & (span - 6'd1)) << (3'd5 - s_q));
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = Start ? LOAD : IDLE;
      LOAD:    state_d = xfer && k_q == 6'd63 ? COMPUTE : LOAD;
      COMPUTE: state_d = stage_end && s_q == 3'd5 ? UNLOAD : COMPUTE;
      UNLOAD:  state_d = j_q[6] ? DONE : UNLOAD;
      default: state_d = IDLE;
    endcase
  end
  assign Busy       = state_q == LOAD || state_q == COMPUTE || state_q == UNLOAD;
  assign Done       = state_q == DONE;
  assign In_Ready   = state_q == LOAD;
  assign Ram_En     = xfer || rd || wr || urd;
  assign Ram_We_A   = xfer || wr;
  assign Ram_We_B   = wr;
  assign Ram_Addr_A = xfer ? {k_q[0], k_q[1], k_q[2], k_q[3], k_q[4], k_q[5]} :
                      rd ? top : wr ? top_q[BF_LAT] : urd ? j_q[5:0] : 6'd0;
  assign Ram_Addr_B = rd ? bot : wr ? bot_q[BF_LAT] : 6'd0;
  assign Ram_DI_A   = xfer ? In_Data : wr ? Bf_Res_A : '0;
  assign Ram_DI_B   = wr ? Bf_Res_B : '0;
  assign Bf_Valid   = v_q[0];
  assign Tw_Addr    = tw_q;
  assign Out_Valid  = ov_q;
  assign Out_Index  = oi_q;
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      c_q     <= '0;
      s_q     <= '0;
      j_q     <= '0;
      v_q     <= '0;
      tw_q    <= '0;
      ov_q    <= 1'b0;
      oi_q    <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= state_q == LOAD ? k_q + 6'(xfer) : '0;
      c_q     <= state_q == COMPUTE && !stage_end ? c_q + CW'(1) : '0;
      s_q     <= state_q == COMPUTE ? s_q + 3'(stage_end) : '0;
      j_q     <= state_q == UNLOAD ? j_q + 7'd1 : '0;
      v_q     <= (v_q << 1) | (BF_LAT + 1)'(rd);
      if (rd) tw_q <= tw;
      ov_q    <= urd;
      if (urd) oi_q <= j_q[5:0];
    end
  end
  always_ff @(posedge Clk) begin
    top_q[0] <= top;
    bot_q[0] <= bot;
    for (int i = 1; i <= BF_LAT; i++) begin
      top_q[i] <= top_q[i-1];
      bot_q[i] <= bot_q[i-1];
    end
  end
endmodule

// File: tb/tb_fft_mem_sequencer.sv
// tb_fft_mem_sequencer: drives frames through the sequencer with a RAM and butterfly model,
// and compares schedule and results with an array-based FFT-flow reference.
module tb_fft_mem_sequencer;
  localparam int L = 2;
  logic Clk = 0, Rst = 1, Start = 0, In_Valid = 0;
  logic [63:0] In_Data = 0;
  logic Busy, Done, In_Ready, Ram_En, Ram_We_A, Ram_We_B, Bf_Valid, Out_Valid;
  logic [5:0] Ram_Addr_A, Ram_Addr_B, Out_Index;
  logic [4:0] Tw_Addr;
  logic [63:0] Ram_DI_A, Ram_DI_B, Ram_DO_A = 0, Ram_DO_B = 0, Bf_Res_A, Bf_Res_B;
  fft_mem_sequencer #(.WIDTH(32), .BF_LAT(L)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Busy(Busy), .Done(Done),
    .In_Valid(In_Valid), .In_Ready(In_Ready), .In_Data(In_Data),
    .Ram_En(Ram_En), .Ram_We_A(Ram_We_A), .Ram_Addr_A(Ram_Addr_A), .Ram_DI_A(Ram_DI_A),
    .Ram_We_B(Ram_We_B), .Ram_Addr_B(Ram_Addr_B), .Ram_DI_B(Ram_DI_B),
    .Ram_DO_A(Ram_DO_A), .Ram_DO_B(Ram_DO_B), .Bf_Valid(Bf_Valid), .Tw_Addr(Tw_Addr),
    .Bf_Res_A(Bf_Res_A), .Bf_Res_B(Bf_Res_B), .Out_Valid(Out_Valid), .Out_Index(Out_Index));
  always #5 Clk = ~Clk;
  int total = 0, bad = 0, cyc = 0, st_cyc, done_cyc, done_n, busy_n, proto_bad;
  logic ir_after;
  bit ident = 0;
  logic [63:0] mem [64];
  logic [63:0] samp [64];
  logic [63:0] exp_out [64];
  logic [127:0] p1 = 0, p2 = 0;
  typedef struct {int cyc; logic [5:0] a; logic [5:0] b; logic [63:0] d;} ev_t;
  ev_t ld_q[$], rd_q[$], wr_q[$], bv_q[$], out_q[$];
  function automatic logic [127:0] bfly(input logic [63:0] a, input logic [63:0] b, input logic [4:0] tw, input bit id);
    if (id) return {a, b};
    return {a + b + 64'(tw), a - b + (64'(tw) << 7)};
  endfunction
  function automatic int bitrev6(input int k);
    int r = 0;
    for (int i = 0; i < 6; i++) if (((k >> i) & 1) != 0) r |= 1 << (5 - i);
    return r;
  endfunction
  always @(posedge Clk) begin
    cyc <= cyc + 1;
    if (Ram_En) begin
      if (Ram_We_A) mem[Ram_Addr_A] <= Ram_DI_A; else Ram_DO_A <= mem[Ram_Addr_A];
      if (Ram_We_B) mem[Ram_Addr_B] <= Ram_DI_B; else Ram_DO_B <= mem[Ram_Addr_B];
    end
    p1 <= bfly(Ram_DO_A, Ram_DO_B, Tw_Addr, ident);
    p2 <= p1;
  end
  assign Bf_Res_A = p2[127:64];
  assign Bf_Res_B = p2[63:0];
  always @(negedge Clk) if (!Rst) begin
    if (Ram_En && Ram_We_A && !Ram_We_B) ld_q.push_back('{cyc, Ram_Addr_A, 6'd0, Ram_DI_A});
    else if (Ram_En && Ram_We_A && Ram_We_B) wr_q.push_back('{cyc, Ram_Addr_A, Ram_Addr_B, 64'd0});
    else if (Ram_En && !Ram_We_A && !Ram_We_B) rd_q.push_back('{cyc, Ram_Addr_A, Ram_Addr_B, 64'd0});
    else if (Ram_We_A || Ram_We_B) proto_bad++;
    if (Bf_Valid) bv_q.push_back('{cyc, {1'b0, Tw_Addr}, 6'd0, 64'd0});
    if (Out_Valid) out_q.push_back('{cyc, Out_Index, 6'd0, Ram_DO_A});
    if (Done) begin done_cyc = cyc; done_n++; end
    if (Busy) busy_n++;
  end
  task automatic build_model;
    logic [63:0] m [64];
    logic [127:0] r;
    int span, top, tw;
    for (int k = 0; k < 64; k++) m[bitrev6(k)] = samp[k];
    for (int s = 0; s < 6; s++)
      for (int b = 0; b < 32; b++) begin
        span = 1 << s;
        top = ((b >> s) << (s + 1)) | (b & (span - 1));
        tw = (b & (span - 1)) << (5 - s);
        r = bfly(m[top], m[top + span], 5'(tw), ident);
        m[top] = r[127:64];
        m[top + span] = r[63:0];
      end
    for (int j = 0; j < 64; j++) exp_out[j] = m[j];
  endtask
  task automatic clear_log;
    ld_q.delete(); rd_q.delete(); wr_q.delete(); bv_q.delete(); out_q.delete();
    done_n = 0; busy_n = 0; proto_bad = 0; done_cyc = -1;
  endtask
  task automatic rand_samples;
    for (int k = 0; k < 64; k++) samp[k] = {$urandom, $urandom};
  endtask
  task automatic feed(input bit gaps);
    int k = 0, n = 0;
    bit tog = 1;
    while (k < 64 && n < 1000) begin
      In_Valid = gaps ? tog : 1'b1;
      In_Data = samp[k];
      if (In_Valid && In_Ready) k++;
      tog = ~tog;
      n++;
      @(posedge Clk); #1;
    end
    In_Valid = 0;
    ir_after = In_Ready;
    total++;
    if (k !== 64) begin bad++; $display("FAIL load_timeout transfers=%0d want 64", k); end
  endtask
  task automatic run_frame(input bit gaps, input bit noisy);
    int n = 0;
    clear_log();
    build_model();
    @(posedge Clk); #1;
    Start = 1; st_cyc = cyc;
    @(posedge Clk); #1;
    Start = 0;
    feed(gaps);
    while (done_n == 0 && n < 3000) begin
      Start = noisy && $urandom_range(0, 7) == 0;
      @(posedge Clk); #1;
      n++;
    end
    Start = 0;
    total++;
    if (done_n == 0) begin bad++; $display("FAIL done_timeout got none want pulse"); end
  endtask
  task automatic test_reset;
    Rst = 1;
    repeat (3) @(posedge Clk);
    #1;
    total++;
    if ({Busy, Done, In_Ready, Ram_En, Ram_We_A, Ram_We_B, Bf_Valid, Out_Valid} !== 8'd0) begin
      bad++; $display("FAIL reset_ctrl got %b want 0", {Busy, Done, In_Ready, Ram_En, Ram_We_A, Ram_We_B, Bf_Valid, Out_Valid}); end
    total++;
    if ({Ram_Addr_A, Ram_Addr_B, Tw_Addr, Out_Index} !== 23'd0) begin
      bad++; $display("FAIL reset_addr got %h want 0", {Ram_Addr_A, Ram_Addr_B, Tw_Addr, Out_Index}); end
    total++;
    if ({Ram_DI_A, Ram_DI_B} !== 128'd0) begin bad++; $display("FAIL reset_data got %h want 0", {Ram_DI_A, Ram_DI_B}); end
    Rst = 0;
    clear_log();
    repeat (4) @(posedge Clk);
    #1;
    total++;
    if (busy_n + ld_q.size() + rd_q.size() !== 0) begin bad++; $display("FAIL idle_quiet got busy=%0d ram=%0d want 0", busy_n, ld_q.size() + rd_q.size()); end
  endtask
  task automatic test_load_order;
    int c0;
    rand_samples();
    run_frame(0, 0);
    total++;
    if (ld_q.size() !== 64) begin bad++; $display("FAIL load_count got %0d want 64", ld_q.size()); end
    for (int k = 0; k < 64 && k < ld_q.size(); k++) begin
      total++;
      if (ld_q[k].a !== 6'(bitrev6(k)) || ld_q[k].d !== samp[k] || ld_q[k].cyc !== st_cyc + 1 + k) begin
        bad++; $display("FAIL load[%0d] got addr=%0d cyc=%0d want addr=%0d cyc=%0d", k, ld_q[k].a, ld_q[k].cyc, bitrev6(k), st_cyc + 1 + k); end
    end
    if (ld_q.size() >= 7) begin
      total++;
      if ({ld_q[1].a, ld_q[2].a, ld_q[3].a, ld_q[6].a} !== {6'd32, 6'd16, 6'd48, 6'd24}) begin
        bad++; $display("FAIL load_examples got %0d %0d %0d %0d want 32 16 48 24", ld_q[1].a, ld_q[2].a, ld_q[3].a, ld_q[6].a); end
    end
    total++;
    if (ir_after !== 1'b0) begin bad++; $display("FAIL in_ready_after got %b want 0", ir_after); end
    c0 = st_cyc + 65;
    total++;
    if (rd_q.size() == 0 || rd_q[0].cyc !== c0) begin bad++; $display("FAIL first_read got %0d want %0d", rd_q.size() ? rd_q[0].cyc : -1, c0); end
  endtask
  task automatic test_compute_schedule;
    int c0, s, b, span, top, tw;
    rand_samples();
    run_frame(0, 0);
    c0 = st_cyc + 65;
    total++;
    if (rd_q.size() !== 256 || wr_q.size() !== 192 || bv_q.size() !== 192) begin
      bad++; $display("FAIL compute_counts got rd=%0d wr=%0d bv=%0d want 256 192 192", rd_q.size(), wr_q.size(), bv_q.size()); end
    else begin
      for (int i = 0; i < 192; i++) begin
        s = i / 32; b = i % 32; span = 1 << s;
        top = ((b >> s) << (s + 1)) | (b & (span - 1));
        tw = (b & (span - 1)) << (5 - s);
        total++;
        if (rd_q[i].a !== 6'(top) || rd_q[i].b !== 6'(top + span) || rd_q[i].cyc !== c0 + s * (64 + L) + 2 * b) begin
          bad++; $display("FAIL read[%0d] got %0d/%0d@%0d want %0d/%0d@%0d", i, rd_q[i].a, rd_q[i].b, rd_q[i].cyc, top, top + span, c0 + s * (64 + L) + 2 * b); end
        total++;
        if (wr_q[i].a !== 6'(top) || wr_q[i].b !== 6'(top + span) || wr_q[i].cyc !== rd_q[i].cyc + 1 + L) begin
          bad++; $display("FAIL write[%0d] got %0d/%0d@%0d want %0d/%0d@%0d", i, wr_q[i].a, wr_q[i].b, wr_q[i].cyc, top, top + span, rd_q[i].cyc + 1 + L); end
        total++;
        if (bv_q[i].a !== 6'(tw) || bv_q[i].cyc !== rd_q[i].cyc + 1) begin
          bad++; $display("FAIL twiddle[%0d] got %0d@%0d want %0d@%0d", i, bv_q[i].a, bv_q[i].cyc, tw, rd_q[i].cyc + 1); end
      end
      total++;
      if ({rd_q[69].a, rd_q[69].b, bv_q[69].a, rd_q[191].a, rd_q[191].b, bv_q[191].a} !== {6'd9, 6'd13, 6'd8, 6'd31, 6'd63, 6'd31}) begin
        bad++; $display("FAIL addr_examples got %0d %0d %0d %0d %0d %0d want 9 13 8 31 63 31", rd_q[69].a, rd_q[69].b, bv_q[69].a, rd_q[191].a, rd_q[191].b, bv_q[191].a); end
      total++;
      if (rd_q[32].cyc - rd_q[0].cyc !== 64 + L) begin bad++; $display("FAIL stage_barrier got %0d want %0d", rd_q[32].cyc - rd_q[0].cyc, 64 + L); end
    end
    total++;
    if (proto_bad !== 0) begin bad++; $display("FAIL port_protocol got %0d bad cycles want 0", proto_bad); end
    for (int j = 0; j < 64 && j < out_q.size(); j++) begin
      total++;
      if (out_q[j].d !== exp_out[j]) begin bad++; $display("FAIL fft_data[%0d] got %h want %h", j, out_q[j].d, exp_out[j]); end
    end
  endtask
  task automatic test_identity_unload;
    int u0;
    ident = 1;
    for (int k = 0; k < 64; k++) samp[k] = 64'(k);
    run_frame(0, 0);
    ident = 0;
    u0 = st_cyc + 65 + 6 * (64 + L);
    total++;
    if (out_q.size() !== 64 || rd_q.size() !== 256) begin bad++; $display("FAIL unload_count got %0d/%0d want 64/256", out_q.size(), rd_q.size()); end
    else begin
      for (int j = 0; j < 64; j++) begin
        total++;
        if (out_q[j].a !== 6'(j) || out_q[j].d !== 64'(bitrev6(j)) || rd_q[192 + j].a !== 6'(j) || out_q[j].cyc !== u0 + j + 1) begin
          bad++; $display("FAIL unload[%0d] got idx=%0d data=%0d cyc=%0d want idx=%0d data=%0d cyc=%0d", j, out_q[j].a, out_q[j].d, out_q[j].cyc, j, bitrev6(j), u0 + j + 1); end
      end
      total++;
      if (out_q[1].d !== 64'd32) begin bad++; $display("FAIL unload_j1 got %0d want 32", out_q[1].d); end
      total++;
      if (done_cyc !== out_q[63].cyc + 1) begin bad++; $display("FAIL done_after_last got %0d want %0d", done_cyc, out_q[63].cyc + 1); end
    end
    total++;
    if (done_cyc - st_cyc !== 1 + 64 + 6 * (64 + L) + 65) begin bad++; $display("FAIL frame_length got %0d want %0d", done_cyc - st_cyc, 1 + 64 + 6 * (64 + L) + 65); end
    total++;
    if (done_n !== 1 || busy_n !== done_cyc - st_cyc - 1) begin bad++; $display("FAIL busy_done got done=%0d busy=%0d want 1 %0d", done_n, busy_n, done_cyc - st_cyc - 1); end
  endtask
  task automatic test_in_valid_gaps;
    rand_samples();
    run_frame(1, 0);
    total++;
    if (ld_q.size() !== 64) begin bad++; $display("FAIL gap_load_count got %0d want 64", ld_q.size()); end
    else begin
      total++;
      if (ld_q[63].cyc - ld_q[0].cyc !== 126 || ld_q[10].a !== 6'(bitrev6(10)) || ld_q[10].d !== samp[10]) begin
        bad++; $display("FAIL gap_load_span got %0d want 126", ld_q[63].cyc - ld_q[0].cyc); end
      total++;
      if (done_cyc - ld_q[63].cyc !== 1 + 6 * (64 + L) + 65) begin bad++; $display("FAIL gap_timing got %0d want %0d", done_cyc - ld_q[63].cyc, 1 + 6 * (64 + L) + 65); end
    end
    for (int j = 0; j < 64 && j < out_q.size(); j++) begin
      total++;
      if (out_q[j].d !== exp_out[j] || out_q[j].a !== 6'(j)) begin bad++; $display("FAIL gap_data[%0d] got %0d:%h want %0d:%h", j, out_q[j].a, out_q[j].d, j, exp_out[j]); end
    end
  endtask
  task automatic test_reset_mid_compute;
    int quiet = 0;
    rand_samples();
    clear_log();
    @(posedge Clk); #1;
    Start = 1;
    @(posedge Clk); #1;
    Start = 0;
    feed(0);
    repeat (100) @(posedge Clk);
    #1;
    total++;
    if (wr_q.size() == 0) begin bad++; $display("FAIL pre_reset_writes got 0 want >0"); end
    Rst = 1;
    @(posedge Clk); #1;
    Rst = 0;
    clear_log();
    total++;
    if (Busy !== 1'b0 || Ram_En !== 1'b0) begin bad++; $display("FAIL after_reset got busy=%b en=%b want 0 0", Busy, Ram_En); end
    repeat (20) @(posedge Clk);
    #1;
    total++;
    if (wr_q.size() + rd_q.size() + bv_q.size() + proto_bad !== 0) begin
      bad++; $display("FAIL stray_after_reset got wr=%0d rd=%0d bv=%0d want 0", wr_q.size(), rd_q.size(), bv_q.size()); end
    rand_samples();
    run_frame(0, 1);
    total++;
    if (out_q.size() !== 64) begin bad++; $display("FAIL second_count got %0d want 64", out_q.size()); end
    for (int j = 0; j < 64 && j < out_q.size(); j++) begin
      total++;
      if (out_q[j].a !== 6'(j) || out_q[j].d !== exp_out[j]) begin bad++; $display("FAIL second[%0d] got %0d:%h want %0d:%h", j, out_q[j].a, out_q[j].d, j, exp_out[j]); end
    end
    total++;
    if (done_n !== 1 || done_cyc - st_cyc !== 1 + 64 + 6 * (64 + L) + 65) begin bad++; $display("FAIL second_timing got %0d want %0d", done_cyc - st_cyc, 1 + 64 + 6 * (64 + L) + 65); end
    repeat (5) begin
      if (Busy !== 1'b0) quiet++;
      @(posedge Clk); #1;
    end
    total++;
    if (quiet !== 0) begin bad++; $display("FAIL no_restart got %0d busy cycles want 0", quiet); end
  endtask
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 0;
    test_reset();
    test_load_order();
    test_compute_schedule();
    test_identity_unload();
    test_in_valid_gaps();
    test_reset_mid_compute();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fft_mem_sequencer.md
# fft_mem_sequencer

Controller that sequences the 64-entry dual-port complex-sample RAM through one 64-point radix-2 DIT FFT frame. It has three phases. LOAD writes the input stream in bit-reversed order. COMPUTE issues 6 stages of 32 in-place butterflies, reading and writing through both RAM ports. UNLOAD reads results in natural order. It sits between the sample source, the RAM, the external fixed-latency butterfly and the twiddle ROM.

## Interface
- WIDTH, 32: real/imag component width; a RAM word is 2*WIDTH bits.
- BF_LAT, 2: butterfly latency in cycles, from Bf_Valid (operands valid) to results valid. Must be even and ≥ 0. An odd value is an elaboration error.

Ports:
- Clk  in  1  single clock, rising edge.
- Rst  in  1  reset; synchronous, active-high.
- Start  in  1  frame start pulse; sampled only in IDLE.
- Busy  out  1  high from the cycle after Start is accepted until Done.
- Done  out  1  one-cycle pulse at frame end.
- In_Valid  in  1  input sample valid.
- In_Ready  out  1  high in LOAD; a sample transfers when In_Valid & In_Ready.
- In_Data  in  2*WIDTH  input sample.
- Ram_En  out  1  RAM enable.
- Ram_We_A  out  1  port A write enable.
- Ram_Addr_A  out  6  port A address.
- Ram_DI_A  out  2*WIDTH  port A write data.
- Ram_We_B  out  1  port B write enable.
- Ram_Addr_B  out  6  port B address.
- Ram_DI_B  out  2*WIDTH  port B write data.
- Ram_DO_A  in  2*WIDTH  port A read data.
- Ram_DO_B  in  2*WIDTH  port B read data.
- Bf_Valid  out  1  Ram_DO_A/Ram_DO_B hold butterfly top/bottom operands this cycle.
- Tw_Addr  out  5  twiddle index, aligned with Bf_Valid.
- Bf_Res_A  in  2*WIDTH  butterfly top result, valid BF_LAT cycles after Bf_Valid.
- Bf_Res_B  in  2*WIDTH  butterfly bottom result, same timing.
- Out_Valid  out  1  Ram_DO_A holds output sample Out_Index.
- Out_Index  out  6  natural-order output index.

## Operation
- States: IDLE → LOAD → COMPUTE → UNLOAD → DONE → IDLE.
- IDLE: all enables low. Start=1 moves to LOAD.
- LOAD:
  - In_Ready=1. On each transfer k (0..63), write In_Data to port A at bitrev6(k) (Ram_En=1, Ram_We_A=1).
  - After transfer 63, go to COMPUTE.
  - In_Valid gaps stall the phase; no timeout.
- COMPUTE: stages s=0..5, butterflies b=0..31 per stage.
  - span = 1<<s
  - top = ((b>>s)<<(s+1)) | (b & (span-1))
  - bot = top + span
  - tw = (b & (span-1)) << (5-s)
- Reads and writes alternate on both ports:
  - A read is issued on even stage-relative cycles 0,2,…,62: Addr_A=top, Addr_B=bot, We=0.
  - Bf_Valid and Tw_Addr are asserted on the following cycle.
  - The write for that butterfly occurs BF_LAT cycles after Bf_Valid (an odd cycle): Addr_A=top, Addr_B=bot, both We=1, DI_A=Bf_Res_A, DI_B=Bf_Res_B.
  - Top/bottom addresses travel in a delay line of depth BF_LAT+1.
- Stage barrier: the next stage's first read issues on the cycle after the current stage's last write. This makes each stage exactly 64+BF_LAT cycles.
- UNLOAD:
  - Read port A at addresses j=0..63, one per cycle.
  - Out_Valid=1 with Out_Index=j on the cycle after the read of j.
  - No backpressure.
- DONE: Done=1 for one cycle, Busy drops in the same cycle, then IDLE.
- Start while not IDLE is ignored.
- Ram_En is 1 exactly on cycles with a read or write issued.
- Never drive both a read and a write on the same port in one cycle.

## Timing
- Reset values: Busy, Done, In_Ready, Ram_En, Ram_We_A, Ram_We_B, Bf_Valid, Out_Valid = 0. Ram_Addr_A, Ram_Addr_B, Ram_DI_A, Ram_DI_B, Tw_Addr, Out_Index = 0. State = IDLE.
- Reset mid-frame: next cycle is IDLE with no RAM write. In-flight butterfly results are discarded. RAM contents are unspecified.
- Start at cycle t: Busy=1 and In_Ready=1 at t+1.
- COMPUTE duration: 6*(64+BF_LAT) cycles.
- UNLOAD: 64 read cycles plus 1 cycle to the last Out_Valid. Done follows on the next cycle.
- Minimum frame with a continuous input stream: 1 + 64 + 6*(64+BF_LAT) + 65 + 1 cycles.
- Counters (load k, butterfly b, stage s, unload j) wrap only by phase transition; no modulo reuse.

## Test plan
- LOAD order: Start, then feed samples 0..63 with no gaps → write addresses in sequence 0, 32, 16, 48, …; sample 6 is written to address 24. In_Ready falls after the 64th transfer.
- Address generation, BF_LAT=2:
  - s=0, b=0 → top 0, bot 1, tw 0.
  - s=2, b=5 → top 9, bot 13, tw 8.
  - s=5, b=31 → top 31, bot 63, tw 31.
  - Each write lands exactly 3 cycles after its read.
- Identity butterfly (Bf_Res = operands delayed BF_LAT), input sample k = k → UNLOAD emits Out_Index j with data bitrev6(j), e.g. j=1 → 32. Done pulses 1 cycle after j=63.
- Stage barrier, BF_LAT=4: the stage-1 first read occurs 68 cycles after the stage-0 first read. No port ever shows a read and a write in the same cycle.
- In_Valid toggling 1,0,1,0 during LOAD → exactly 64 writes. Phase timing is otherwise unchanged.
- Rst asserted mid-COMPUTE, then Start with a new frame → no stray writes after reset. The second frame completes with correct Out_Index sequence 0..63. Start pulses during Busy are ignored.
